// File: rtl/dsc_pkg.sv
// Shared definitions for the demux sequence controller: controller state
// encoding, the maximum channel count and the selector width.
package dsc_pkg;

  localparam int MAX_CH = 11;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dsc_state_e;

endpackage

// File: rtl/dsc_next_channel.sv
// Channel sequencing helper: given the current channel and the set of active
// channels, finds the lowest active channel (job start / wrap target) and the
// next active channel above the current one, flagging a wrap when none exists.
module dsc_next_channel
  import dsc_pkg::*;
(
  input  logic [SEL_W-1:0]  cur_ch,
  input  logic [MAX_CH-1:0] active,
  output logic [SEL_W-1:0]  first_ch,
  output logic [SEL_W-1:0]  next_ch,
  output logic              wrap,
  output logic              any_active
);

  // Lowest active channel; descending scan so the last hit wins.
  always_comb begin
    first_ch   = '0;
    any_active = 1'b0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (active[i]) begin
        first_ch   = SEL_W'(i);
        any_active = 1'b1;
      end
    end
  end

  // Lowest active channel above cur_ch, else wrap to the first active one.
  always_comb begin
    next_ch = first_ch;
    wrap    = 1'b1;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (active[i] && (SEL_W'(i) > cur_ch)) begin
        next_ch = SEL_W'(i);
        wrap    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/demux_seq_controller.sv
// Demux sequence controller: streams upstream words to a demultiplexer,
// BURST_LEN words per channel, sweeping the channels DSC_pass_num times per
// job. Outputs to the demultiplexer are registered (one cycle latency).
// Optional feature: define DSC_CH_MASK_EN to add DSC_ch_mask, a per-job
// mask of channels to skip.
module demux_seq_controller
  import dsc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 9,
  parameter int NUM_CH     = 11
) (
  input  logic                  DSC_CLOCK_50,
  input  logic                  DSC_RESET_InHigh,
  input  logic                  DSC_start,
  input  logic [7:0]            DSC_pass_num,
  input  logic [DATA_WIDTH-1:0] DSC_in_data,
  input  logic                  DSC_in_valid,
  output logic                  DSC_in_ready,
  input  logic [MAX_CH-1:0]     DSC_ch_ready,
`ifdef DSC_CH_MASK_EN
  input  logic [MAX_CH-1:0]     DSC_ch_mask,
`endif
  output logic [DATA_WIDTH-1:0] DSC_data_out,
  output logic [SEL_W-1:0]      DSC_selector,
  output logic                  DSC_demux_en,
  output logic                  DSC_busy,
  output logic                  DSC_done
);

  localparam logic [MAX_CH-1:0] CH_ALL = MAX_CH'((1 << NUM_CH) - 1);

  dsc_state_e        state, state_nx;
  logic [SEL_W-1:0]  ch;
  logic [7:0]        burst_cnt;
  logic [7:0]        pass_cnt;
  logic [7:0]        pass_tgt;
  logic [MAX_CH-1:0] active;
  logic [SEL_W-1:0]  first_ch, next_ch;
  logic              wrap, any_active;
  logic              acc, burst_last, pass_last;

`ifdef DSC_CH_MASK_EN
  logic [MAX_CH-1:0] act_q;

  // Capture the active channel set at job start.
  always_ff @(posedge DSC_CLOCK_50 or posedge DSC_RESET_InHigh) begin
    if (DSC_RESET_InHigh)                   act_q <= '0;
    else if (state == ST_IDLE && DSC_start) act_q <= CH_ALL & ~DSC_ch_mask;
  end

  // In IDLE the live mask drives the helper so the start decision and the
  // first channel reflect the mask being sampled this cycle.
  assign active = (state == ST_IDLE) ? (CH_ALL & ~DSC_ch_mask) : act_q;
`else
  assign active = CH_ALL;
`endif

  dsc_next_channel u_next (
    .cur_ch     (ch),
    .active     (active),
    .first_ch   (first_ch),
    .next_ch    (next_ch),
    .wrap       (wrap),
    .any_active (any_active)
  );

  assign DSC_in_ready = (state == ST_RUN) & DSC_ch_ready[ch];
  assign acc          = DSC_in_valid & DSC_in_ready;
  assign burst_last   = (burst_cnt == 8'(BURST_LEN - 1));
  assign pass_last    = (pass_cnt == pass_tgt - 8'd1);
  assign DSC_busy     = (state == ST_RUN);
  assign DSC_done     = (state == ST_DONE);

  // State register.
  always_ff @(posedge DSC_CLOCK_50 or posedge DSC_RESET_InHigh) begin
    if (DSC_RESET_InHigh) state <= ST_IDLE;
    else                  state <= state_nx;
  end

  // Next-state: empty jobs go straight to DONE; the job ends on the word
  // that closes the last burst of the last channel of the last pass.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (DSC_start)
                 state_nx = (DSC_pass_num == 8'd0 || !any_active) ? ST_DONE : ST_RUN;
      ST_RUN:  if (acc && burst_last && wrap && pass_last) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Job counters: load at start, step on each accepted word, frozen on stall.
  always_ff @(posedge DSC_CLOCK_50 or posedge DSC_RESET_InHigh) begin
    if (DSC_RESET_InHigh) begin
      ch        <= '0;
      burst_cnt <= '0;
      pass_cnt  <= '0;
      pass_tgt  <= '0;
    end else if (state == ST_IDLE) begin
      if (DSC_start) begin
        ch        <= first_ch;
        burst_cnt <= '0;
        pass_cnt  <= '0;
        pass_tgt  <= DSC_pass_num;
      end
    end else if (state == ST_RUN && acc) begin
      if (burst_last) begin
        burst_cnt <= '0;
        ch        <= next_ch;
        if (wrap) pass_cnt <= pass_cnt + 8'd1;
      end else begin
        burst_cnt <= burst_cnt + 8'd1;
      end
    end
  end

  // Registered demux outputs; the selector holds between accepted words.
  always_ff @(posedge DSC_CLOCK_50 or posedge DSC_RESET_InHigh) begin
    if (DSC_RESET_InHigh) begin
      DSC_data_out <= '0;
      DSC_selector <= '0;
      DSC_demux_en <= 1'b0;
    end else begin
      DSC_data_out <= acc ? DSC_in_data : '0;
      DSC_demux_en <= acc;
      if (acc) DSC_selector <= ch;
    end
  end

endmodule

// File: tb/tb_demux_seq_controller.sv
// Bench for demux_seq_controller. Instance a: BURST_LEN=2, NUM_CH=3 driven
// from a vector table plus a two-pass sequence. Instance b: default
// parameters, mid-job reset. Instance c (DSC_CH_MASK_EN only): NUM_CH=4 mask.
module tb_demux_seq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, start_c;
  logic [7:0]  pass_num;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [10:0] ch_ready;
  logic        rdy_a, en_a, busy_a, done_a;
  logic [7:0]  dout_a;
  logic [3:0]  sel_a;
  logic        rdy_b, en_b, busy_b, done_b;
  logic [7:0]  dout_b;
  logic [3:0]  sel_b;
`ifdef DSC_CH_MASK_EN
  logic [10:0] mask_ab, mask_c;
  logic        rdy_c, en_c, busy_c, done_c;
  logic [7:0]  dout_c;
  logic [3:0]  sel_c;
`endif

  always #5 clk = ~clk;

  demux_seq_controller #(.DATA_WIDTH(8), .BURST_LEN(2), .NUM_CH(3)) u_a (
    .DSC_CLOCK_50(clk), .DSC_RESET_InHigh(rst), .DSC_start(start_a),
    .DSC_pass_num(pass_num), .DSC_in_data(in_data), .DSC_in_valid(in_valid),
    .DSC_in_ready(rdy_a), .DSC_ch_ready(ch_ready),
`ifdef DSC_CH_MASK_EN
    .DSC_ch_mask(mask_ab),
`endif
    .DSC_data_out(dout_a), .DSC_selector(sel_a), .DSC_demux_en(en_a),
    .DSC_busy(busy_a), .DSC_done(done_a));

  demux_seq_controller u_b (
    .DSC_CLOCK_50(clk), .DSC_RESET_InHigh(rst), .DSC_start(start_b),
    .DSC_pass_num(pass_num), .DSC_in_data(in_data), .DSC_in_valid(in_valid),
    .DSC_in_ready(rdy_b), .DSC_ch_ready(ch_ready),
`ifdef DSC_CH_MASK_EN
    .DSC_ch_mask(mask_ab),
`endif
    .DSC_data_out(dout_b), .DSC_selector(sel_b), .DSC_demux_en(en_b),
    .DSC_busy(busy_b), .DSC_done(done_b));

`ifdef DSC_CH_MASK_EN
  demux_seq_controller #(.DATA_WIDTH(8), .BURST_LEN(1), .NUM_CH(4)) u_c (
    .DSC_CLOCK_50(clk), .DSC_RESET_InHigh(rst), .DSC_start(start_c),
    .DSC_pass_num(pass_num), .DSC_in_data(in_data), .DSC_in_valid(in_valid),
    .DSC_in_ready(rdy_c), .DSC_ch_ready(ch_ready), .DSC_ch_mask(mask_c),
    .DSC_data_out(dout_c), .DSC_selector(sel_c), .DSC_demux_en(en_c),
    .DSC_busy(busy_c), .DSC_done(done_c));
`endif

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        start;
    logic [7:0]  pass;
    logic        valid;
    logic [10:0] rdy;
    logic [7:0]  data;
    logic        e_rdy;
    logic        e_en;
    logic [3:0]  e_sel;
    logic [7:0]  e_data;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  function automatic vec_t mk(logic st, logic [7:0] ps, logic v, logic [10:0] r,
                              logic [7:0] d, logic er, logic ee, logic [3:0] es,
                              logic [7:0] ed, logic eb, logic edn);
    vec_t t;
    t.start = st; t.pass = ps; t.valid = v; t.rdy = r; t.data = d;
    t.e_rdy = er; t.e_en = ee; t.e_sel = es; t.e_data = ed;
    t.e_busy = eb; t.e_done = edn;
    return t;
  endfunction

  localparam logic [10:0] ALL = 11'h7FF;
  localparam logic [10:0] NO1 = 11'h7FD;

  vec_t tbl[$];

  initial begin
    // Single pass, 2 words x 3 channels, then DONE and back to IDLE.
    tbl.push_back(mk(1, 1, 1, ALL, 8'hA0, 0, 0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 1, ALL, 8'hA1, 1, 1, 0, 8'hA1, 1, 0));
    tbl.push_back(mk(0, 1, 1, ALL, 8'hA2, 1, 1, 0, 8'hA2, 1, 0));
    tbl.push_back(mk(0, 1, 1, ALL, 8'hA3, 1, 1, 1, 8'hA3, 1, 0));
    tbl.push_back(mk(0, 1, 1, ALL, 8'hA4, 1, 1, 1, 8'hA4, 1, 0));
    tbl.push_back(mk(0, 1, 1, ALL, 8'hA5, 1, 1, 2, 8'hA5, 1, 0));
    tbl.push_back(mk(0, 1, 1, ALL, 8'hA6, 1, 1, 2, 8'hA6, 0, 1));
    tbl.push_back(mk(0, 1, 1, ALL, 8'hA7, 0, 0, 2, 8'h00, 0, 0));
    // Channel 1 not ready for 5 cycles (start ignored while running),
    // one cycle without valid, then resume on channel 1.
    tbl.push_back(mk(1, 1, 1, ALL, 8'hB0, 0, 0, 2, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 1, ALL, 8'hB1, 1, 1, 0, 8'hB1, 1, 0));
    tbl.push_back(mk(0, 1, 1, ALL, 8'hB2, 1, 1, 0, 8'hB2, 1, 0));
    tbl.push_back(mk(0, 1, 1, NO1, 8'hC0, 0, 0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 1, NO1, 8'hC1, 0, 0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 1, 1, NO1, 8'hC2, 0, 0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 1, NO1, 8'hC3, 0, 0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 1, NO1, 8'hC4, 0, 0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 0, ALL, 8'hC5, 1, 0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 1, ALL, 8'hB3, 1, 1, 1, 8'hB3, 1, 0));
    tbl.push_back(mk(0, 1, 1, ALL, 8'hB4, 1, 1, 1, 8'hB4, 1, 0));
    tbl.push_back(mk(0, 1, 1, ALL, 8'hB5, 1, 1, 2, 8'hB5, 1, 0));
    tbl.push_back(mk(0, 1, 1, ALL, 8'hB6, 1, 1, 2, 8'hB6, 0, 1));
    tbl.push_back(mk(0, 1, 1, ALL, 8'hB7, 0, 0, 2, 8'h00, 0, 0));
    // Zero passes: DONE right after start, nothing transferred.
    tbl.push_back(mk(1, 0, 1, ALL, 8'hD0, 0, 0, 2, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 1, ALL, 8'hD1, 0, 0, 2, 8'h00, 0, 0));

    rst = 1'b1; start_a = 0; start_b = 0; start_c = 0;
    pass_num = 0; in_data = 0; in_valid = 0; ch_ready = 0;
`ifdef DSC_CH_MASK_EN
    mask_ab = '0; mask_c = '0;
`endif
    #3;
    check("reset_a_en",   en_a,   0);
    check("reset_a_dout", dout_a, 0);
    check("reset_a_sel",  sel_a,  0);
    check("reset_a_busy", busy_a, 0);
    check("reset_a_done", done_a, 0);
    check("reset_b_en",   en_b,   0);
    @(posedge clk); #1 rst = 1'b0;

    // Table-driven vectors on instance a.
    for (int i = 0; i < tbl.size(); i++) begin
      start_a  = tbl[i].start;
      pass_num = tbl[i].pass;
      in_valid = tbl[i].valid;
      ch_ready = tbl[i].rdy;
      in_data  = tbl[i].data;
      #1;
      check($sformatf("v%0d_in_ready", i), rdy_a, tbl[i].e_rdy);
      @(posedge clk); #1;
      check($sformatf("v%0d_en",   i), en_a,   tbl[i].e_en);
      check($sformatf("v%0d_sel",  i), sel_a,  tbl[i].e_sel);
      check($sformatf("v%0d_data", i), dout_a, tbl[i].e_data);
      check($sformatf("v%0d_busy", i), busy_a, tbl[i].e_busy);
      check($sformatf("v%0d_done", i), done_a, tbl[i].e_done);
    end
    start_a = 0;

    // Two passes on instance a: 12 words, selector follows (k/2)%3.
    start_a = 1; pass_num = 2; in_valid = 1; ch_ready = ALL;
    @(posedge clk); #1 start_a = 0;
    for (int k = 0; k < 12; k++) begin
      in_data = 8'h40 + 8'(k);
      @(posedge clk); #1;
      check($sformatf("p2_%0d_en",   k), en_a,   1);
      check($sformatf("p2_%0d_sel",  k), sel_a,  (k / 2) % 3);
      check($sformatf("p2_%0d_data", k), dout_a, 32'h40 + k);
      check($sformatf("p2_%0d_done", k), done_a, (k == 11) ? 1 : 0);
    end
    @(posedge clk); #1;
    check("p2_done_clear", done_a, 0);
    check("p2_idle_en",    en_a,   0);

    // Instance b (11 channels, burst 9): reset after 4 words.
    start_b = 1; pass_num = 1; in_valid = 1; ch_ready = ALL;
    @(posedge clk); #1 start_b = 0;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'h50 + 8'(k);
      @(posedge clk); #1;
    end
    check("b_pre_rst_data", dout_b, 32'h53);
    #2 rst = 1'b1;
    #1;
    check("b_rst_data",  dout_b, 0);
    check("b_rst_en",    en_b,   0);
    check("b_rst_sel",   sel_b,  0);
    check("b_rst_busy",  busy_b, 0);
    check("b_rst_done",  done_b, 0);
    check("b_rst_ready", rdy_b,  0);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("b_abort_done_%0d", k), done_b, 0);
      check($sformatf("b_abort_busy_%0d", k), busy_b, 0);
    end
    // Restart: 9 words on channel 0, 10th word on channel 1.
    start_b = 1;
    @(posedge clk); #1 start_b = 0;
    for (int k = 0; k < 10; k++) begin
      in_data = 8'h60 + 8'(k);
      @(posedge clk); #1;
      check($sformatf("b_re_%0d_en",   k), en_b,   1);
      check($sformatf("b_re_%0d_sel",  k), sel_b,  (k < 9) ? 0 : 1);
      check($sformatf("b_re_%0d_data", k), dout_b, 32'h60 + k);
    end
    in_valid = 0;
    @(posedge clk); #1;
    check("b_stop_en", en_b, 0);

`ifdef DSC_CH_MASK_EN
    // Mask 101 on 4 channels, two passes: selectors 1,3,1,3. The mask
    // changes after start to show it is sampled only at start.
    mask_c = 11'b00000000101; start_c = 1; pass_num = 2; in_valid = 1;
    @(posedge clk); #1 start_c = 0; mask_c = '0;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'h70 + 8'(k);
      @(posedge clk); #1;
      check($sformatf("m_%0d_en",   k), en_c,   1);
      check($sformatf("m_%0d_sel",  k), sel_c,  (k % 2 == 1) ? 3 : 1);
      check($sformatf("m_%0d_done", k), done_c, (k == 3) ? 1 : 0);
    end
    @(posedge clk); #1;
    check("m_done_clear", done_c, 0);
    mask_c = 11'h7FF; start_c = 1;
    @(posedge clk); #1 start_c = 0;
    check("m_all_done", done_c, 1);
    check("m_all_busy", busy_c, 0);
    check("m_all_en",   en_c,   0);
    @(posedge clk); #1;
    check("m_all_done_clear", done_c, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
